// File: rtl/router_pkg.sv
// router_pkg: shared router constants, port one-hots and arbiter state encoding.
package router_pkg;
    localparam int NUM_PORTS = 4;
    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} arb_state_t;
    localparam logic [NUM_PORTS-1:0] PORT0 = 4'b0001;
    localparam logic [NUM_PORTS-1:0] PORT1 = 4'b0010;
    localparam logic [NUM_PORTS-1:0] PORT2 = 4'b0100;
    localparam logic [NUM_PORTS-1:0] PORT3 = 4'b1000;
endpackage

// File: rtl/rr_packet_arbiter_if.sv
// rr_packet_arbiter_if: requester/channel handshake bundle for the packet arbiter.
interface rr_packet_arbiter_if;
    import router_pkg::*;
    logic [NUM_PORTS-1:0] req;
    logic [NUM_PORTS-1:0] tail;
    logic [NUM_PORTS-1:0] grant;
    logic [NUM_PORTS-1:0] fire;
    logic [NUM_PORTS-1:0] ptr;
    logic                 out_ready;
    logic                 busy;
    modport master(output req, tail, out_ready, input grant, fire, busy, ptr);
    modport slave(input req, tail, out_ready, output grant, fire, busy, ptr);
endinterface

// File: rtl/rr_pick.sv
// rr_pick: one-hot round-robin pick of the first request at or above ptr, with wrap.
import router_pkg::*;
module rr_pick #(
    parameter int N = NUM_PORTS
) (
    input  logic [N-1:0] req,
    input  logic [N-1:0] ptr,
    output logic [N-1:0] winner,
    output logic         any_req
);
    logic [2*N-1:0] dbl;
    logic [2*N-1:0] hit;
    // Subtracting ptr clears everything below it; the upper copy supplies the wrap.
    assign dbl     = {req, req};
    assign hit     = dbl & ~(dbl - {{N{1'b0}}, ptr});
    assign winner  = hit[N-1:0] | hit[2*N-1:N];
    assign any_req = |req;
endmodule

// File: rtl/rr_packet_arbiter.sv
// rr_packet_arbiter: whole-packet round-robin arbiter for one output channel.
import router_pkg::*;
module rr_packet_arbiter #(
    parameter int N = NUM_PORTS
) (
    input logic clk,
    input logic rst_n,
    rr_packet_arbiter_if.slave bus
);
    arb_state_t   state;
    logic [N-1:0] grant;
    logic [N-1:0] ptr;
    logic [N-1:0] winner;
    logic [N-1:0] fire;
    logic         any_req;
    logic         busy;
    rr_pick #(.N(N)) u_pick (
        .req(bus.req),
        .ptr(ptr),
        .winner(winner),
        .any_req(any_req)
    );
    assign fire      = grant & bus.req & {N{bus.out_ready}};
    assign bus.fire  = fire;
    assign bus.grant = grant;
    assign bus.busy  = busy;
    assign bus.ptr   = ptr;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            grant <= '0;
            busy  <= 1'b0;
            ptr   <= PORT0;
        end else if (state == IDLE) begin
            if (any_req) begin
                state <= LOCKED;
                grant <= winner;
                busy  <= 1'b1;
            end
        end else if (|(fire & bus.tail)) begin
            // Priority moves to the requester after the one whose packet just ended.
            state <= IDLE;
            grant <= '0;
            busy  <= 1'b0;
            ptr   <= {grant[N-2:0], grant[N-1]};
        end
    end
endmodule
